mc_ctrl_unit: RTL and testbench

Parametrised next-generation multi-cycle MIPS control FSM for the MSOC CPU. It sequences IF/ID/EX/MEM/WB and drives all datapath mux and enable controls. Over the previous controller it adds:
- MIO_ready wait-states on every memory access state
- precise exceptions for illegal opcode and arithmetic overflow, with EPC capture and a vector jump
- jalr as a proper state
- sll/srl/sltu support

---
 rtl/mc_ctrl_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with
// MIO_ready wait-states, precise exceptions (illegal op, overflow) and jalr.
// Optional bus timeout on memory wait-states: define MCTRL_TIMEOUT_EN.
module mc_ctrl_unit #(
  parameter int STATE_W  = 5,
  parameter int OVF_TRAP = 1,
  parameter int WAIT_MAX = 15
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        Inst_in,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               CPU_MIO,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALU_operation,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic               unsign,
  output logic               ExcWrite,
  output logic [1:0]         exc_cause
);
  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_MEM_EX = 5'd2, S_MEM_RD = 5'd3, S_LW_WB = 5'd4,
    S_MEM_W = 5'd5, S_R_EX = 5'd6, S_R_WB = 5'd7, S_BEQ = 5'd8, S_J = 5'd9,
    S_I_EX = 5'd10, S_I_WB = 5'd11, S_LUI_WB = 5'd12, S_BNE = 5'd13, S_JR = 5'd14,
    S_JAL = 5'd15, S_EXC = 5'd16, S_JALR = 5'd17
  } state_t;

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_XOR = 3'b011,
                         A_NOR = 3'b100, A_SRL = 3'b101, A_SUB = 3'b110, A_SLT = 3'b111;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_JALR = 6'h09,
                         F_ADD = 6'h20, F_SUB = 6'h22, F_SLTU = 6'h2B;

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       run_q;     // low until the first edge after reset release
  logic [5:0] opcode, funct;
  logic       unused_bits;

  assign opcode      = Inst_in[31:26];
  assign funct       = Inst_in[5:0];
  assign unused_bits = ^{Inst_in[25:6], zero};  // rs/rt/rd/imm and zero are datapath-only
  assign state_out   = STATE_W'(state_q);

  // R-type funct -> ALU op; sll and srl share SRL, datapath tells them apart by funct[1]
  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: r_alu = A_ADD;
      6'h22, 6'h23: r_alu = A_SUB;
      6'h24:        r_alu = A_AND;
      6'h25:        r_alu = A_OR;
      6'h26:        r_alu = A_XOR;
      6'h27:        r_alu = A_NOR;
      6'h2A, 6'h2B: r_alu = A_SLT;
      F_SLL, F_SRL: r_alu = A_SRL;
      default:      r_alu = A_ADD;
    endcase
  endfunction

  function automatic logic r_known(input logic [5:0] f);
    case (f)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B, F_SLL, F_SRL: r_known = 1'b1;
      default:                    r_known = 1'b0;
    endcase
  endfunction

`ifdef MCTRL_TIMEOUT_EN
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              mem_hold;
  assign mem_hold = (state_q == S_IF || state_q == S_MEM_RD || state_q == S_MEM_W) && !MIO_ready;
`endif

  // State, latched cause, run flag (and wait counter) registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      cause_q <= 2'b00;
      run_q   <= 1'b0;
`ifdef MCTRL_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      run_q   <= 1'b1;
`ifdef MCTRL_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // Next-state and exception cause capture
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IF:     if (run_q && MIO_ready) state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_R: begin
            if (funct == F_JR)        state_d = S_JR;
            else if (funct == F_JALR) state_d = S_JALR;
            else if (r_known(funct))  state_d = S_R_EX;
            else begin state_d = S_EXC; cause_d = 2'b01; end
          end
          OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EX;
          OP_LUI:        state_d = S_LUI_WB;
          OP_LW, OP_SW:  state_d = S_MEM_EX;
          OP_BEQ:        state_d = S_BEQ;
          OP_BNE:        state_d = S_BNE;
          OP_J:          state_d = S_J;
          OP_JAL:        state_d = S_JAL;
          default: begin state_d = S_EXC; cause_d = 2'b01; end
        endcase
      end
      S_MEM_EX: state_d = (opcode == OP_SW) ? S_MEM_W : S_MEM_RD;
      S_MEM_RD: if (MIO_ready) state_d = S_LW_WB;
      S_MEM_W:  if (MIO_ready) state_d = S_IF;
      S_R_EX: begin
        if (OVF_TRAP != 0 && overflow && (funct == F_ADD || funct == F_SUB)) begin
          state_d = S_EXC; cause_d = 2'b10;
        end else state_d = S_R_WB;
      end
      S_I_EX: begin
        if (OVF_TRAP != 0 && overflow && opcode == OP_ADDI) begin
          state_d = S_EXC; cause_d = 2'b10;
        end else state_d = S_I_WB;
      end
      default:  state_d = S_IF;  // all single-cycle WB/branch/jump/EXC states
    endcase
`ifdef MCTRL_TIMEOUT_EN
    if (mem_hold && wait_q == WCNT_W'(WAIT_MAX - 1)) begin
      state_d = S_EXC; cause_d = 2'b11;
    end
`endif
    if (state_d == S_IF) cause_d = 2'b00;
  end

`ifdef MCTRL_TIMEOUT_EN
  // Wait counter: counts held cycles, clears whenever the state moves
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (mem_hold)      wait_d = wait_q + 1'b1;
  end
`endif

  // Moore-style output decode of state and IR
  always_comb begin
    MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0; CPU_MIO = 1'b0;
    RegWrite = 1'b0; RegDst = 2'b00; MemtoReg = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 2'b00;
    ALU_operation = A_AND; PCSource = 2'b00; PCWrite = 1'b0; PCWriteCond = 1'b0;
    Branch = 1'b0; unsign = 1'b0; ExcWrite = 1'b0; exc_cause = 2'b00;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1; CPU_MIO = 1'b1; ALUSrcB = 2'b01; ALU_operation = A_ADD;
        IRWrite = run_q && MIO_ready;
        PCWrite = run_q && MIO_ready;
      end
      S_ID:     begin ALUSrcB = 2'b11; ALU_operation = A_ADD; end
      S_MEM_EX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = A_ADD; end
      S_MEM_RD: begin MemRead = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
      S_LW_WB:  begin RegWrite = 1'b1; MemtoReg = 2'b01; end
      S_MEM_W:  begin MemWrite = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
      S_R_EX: begin
        ALUSrcA = 1'b1; ALU_operation = r_alu(funct);
        unsign  = (funct == F_SLTU);
      end
      S_R_WB:   begin RegWrite = 1'b1; RegDst = 2'b01; end
      S_I_EX: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        case (opcode)
          OP_SLTI:  ALU_operation = A_SLT;
          OP_SLTIU: begin ALU_operation = A_SLT; unsign = 1'b1; end
          OP_ANDI:  begin ALU_operation = A_AND; unsign = 1'b1; end
          OP_ORI:   begin ALU_operation = A_OR;  unsign = 1'b1; end
          OP_XORI:  begin ALU_operation = A_XOR; unsign = 1'b1; end
          default:  ALU_operation = A_ADD;
        endcase
      end
      S_I_WB:   RegWrite = 1'b1;
      S_LUI_WB: begin RegWrite = 1'b1; MemtoReg = 2'b11; end
      S_BEQ, S_BNE: begin
        ALUSrcA = 1'b1; ALU_operation = A_SUB; PCWriteCond = 1'b1; PCSource = 2'b01;
        Branch  = (state_q == S_BEQ);
      end
      S_J:      begin PCWrite = 1'b1; PCSource = 2'b10; end
      S_JAL: begin
        PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10;
      end
      S_JR:     begin PCWrite = 1'b1; PCSource = 2'b01; ALUSrcA = 1'b1; ALU_operation = A_OR; end
      S_JALR: begin
        PCWrite = 1'b1; PCSource = 2'b01; ALUSrcA = 1'b1; ALU_operation = A_OR;
        RegWrite = 1'b1; RegDst = 2'b01; MemtoReg = 2'b10;
      end
      S_EXC:    begin ExcWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b11; exc_cause = cause_q; end
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: stimulus pushes hand-computed control
// vectors, a monitor pops one per cycle and compares against the DUT.
module tb_mc_ctrl_unit;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [31:0] Inst_in = 32'h0;
  logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0;
  logic [4:0]  state_out;
  logic MemRead, MemWrite, IorD, IRWrite, CPU_MIO, RegWrite, ALUSrcA;
  logic PCWrite, PCWriteCond, Branch, unsign, ExcWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, exc_cause;
  logic [2:0] ALU_operation;

  int checks = 0, errors = 0, step_no = 0;

  typedef struct { logic [29:0] v; int step; } exp_t;
  exp_t sb_q[$];

  mc_ctrl_unit #(.STATE_W(5), .OVF_TRAP(1), .WAIT_MAX(15)) dut (
    .clk(clk), .reset_n(reset_n), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .state_out(state_out), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite), .CPU_MIO(CPU_MIO), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_operation(ALU_operation),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .unsign(unsign), .ExcWrite(ExcWrite), .exc_cause(exc_cause));

  always #5 clk = ~clk;

  // mem = {MemRead,MemWrite,IorD,IRWrite,CPU_MIO,RegWrite}; pcb = {PCWrite,PCWriteCond,Branch,unsign}
  function automatic logic [29:0] v(input logic [4:0] st, input logic [5:0] mem,
    input logic [1:0] rd, input logic [1:0] mtr, input logic sa, input logic [1:0] sb,
    input logic [2:0] alu, input logic [1:0] pcs, input logic [3:0] pcb,
    input logic exw, input logic [1:0] cause);
    return {st, mem, rd, mtr, sa, sb, alu, pcs, pcb, exw, cause};
  endfunction

  logic [29:0] act;
  assign act = {state_out, MemRead, MemWrite, IorD, IRWrite, CPU_MIO, RegWrite, RegDst,
                MemtoReg, ALUSrcA, ALUSrcB, ALU_operation, PCSource, PCWrite, PCWriteCond,
                Branch, unsign, ExcWrite, exc_cause};

  // Monitor: every cycle the DUT presents a control vector; compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL ctrl_vec step %0d: got %h (state %0d) expected %h (state %0d)",
                   e.step, act, act[29:25], e.v, e.v[29:25]);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [31:0] inst, input logic mio,
                      input logic ovf, input logic [29:0] ev);
    exp_t e;
    @(posedge clk); #1;
    reset_n = rst; Inst_in = inst; MIO_ready = mio; overflow = ovf;
    step_no++;
    e.v = ev; e.step = step_no;
    sb_q.push_back(e);
  endtask

  logic [29:0] V_IF0, V_IF1, V_ID, V_MEMEX, V_MEMRD, V_LWWB, V_MEMW, V_REX, V_RWB;
  logic [29:0] V_BEQ, V_BNE, V_IEX, V_IWB, V_LUI, V_EXC_OVF, V_EXC_ILL, V_EXC_TO, V_JALR;
  localparam logic [31:0] I_LW = 32'h8C880004, I_ADD = 32'h01095020, I_ILL = 32'hFC000000,
    I_JALR = 32'h0100F809, I_SW = 32'hAC880004, I_BEQ = 32'h11090003, I_BNE = 32'h15090003,
    I_ANDI = 32'h3088000F, I_LUI = 32'h3C081234;

  initial begin
    V_IF0     = v(5'd0,  6'b100010, 2'b00, 2'b00, 1'b0, 2'b01, 3'b010, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_IF1     = v(5'd0,  6'b100110, 2'b00, 2'b00, 1'b0, 2'b01, 3'b010, 2'b00, 4'b1000, 1'b0, 2'b00);
    V_ID      = v(5'd1,  6'b000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b010, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_MEMEX   = v(5'd2,  6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b010, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_MEMRD   = v(5'd3,  6'b101010, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_LWWB    = v(5'd4,  6'b000001, 2'b00, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_MEMW    = v(5'd5,  6'b011010, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_REX     = v(5'd6,  6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b010, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_RWB     = v(5'd7,  6'b000001, 2'b01, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_BEQ     = v(5'd8,  6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b110, 2'b01, 4'b0110, 1'b0, 2'b00);
    V_IEX     = v(5'd10, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000, 2'b00, 4'b0001, 1'b0, 2'b00);
    V_IWB     = v(5'd11, 6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_LUI     = v(5'd12, 6'b000001, 2'b00, 2'b11, 1'b0, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 2'b00);
    V_BNE     = v(5'd13, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b110, 2'b01, 4'b0100, 1'b0, 2'b00);
    V_EXC_ILL = v(5'd16, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b11, 4'b1000, 1'b1, 2'b01);
    V_EXC_OVF = v(5'd16, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b11, 4'b1000, 1'b1, 2'b10);
    V_EXC_TO  = v(5'd16, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b11, 4'b1000, 1'b1, 2'b11);
    V_JALR    = v(5'd17, 6'b000001, 2'b01, 2'b10, 1'b1, 2'b00, 3'b001, 2'b01, 4'b1000, 1'b0, 2'b00);

    // reset held with MIO_ready high: IF outputs, no IRWrite/PCWrite
    step(1'b0, I_LW, 1'b1, 1'b0, V_IF0);
    step(1'b1, I_LW, 1'b1, 1'b0, V_IF0);   // released, first edge not yet seen
    step(1'b1, I_LW, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_LW, 1'b1, 1'b0, V_ID);
    step(1'b1, I_LW, 1'b1, 1'b0, V_MEMEX);
    step(1'b1, I_LW, 1'b0, 1'b0, V_MEMRD);
    step(1'b0, I_LW, 1'b1, 1'b0, V_IF0);   // async reset mid-MEM_RD
    step(1'b1, I_LW, 1'b1, 1'b0, V_IF0);
    // lw with three wait-states in MEM_RD: 0,1,2,3,3,3,3,4,0
    step(1'b1, I_LW, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_LW, 1'b1, 1'b0, V_ID);
    step(1'b1, I_LW, 1'b1, 1'b0, V_MEMEX);
    step(1'b1, I_LW, 1'b0, 1'b0, V_MEMRD);
    step(1'b1, I_LW, 1'b0, 1'b0, V_MEMRD);
    step(1'b1, I_LW, 1'b0, 1'b0, V_MEMRD);
    step(1'b1, I_LW, 1'b1, 1'b0, V_MEMRD);
    step(1'b1, I_LW, 1'b1, 1'b0, V_LWWB);
    // add with overflow: 1,6,16,0 and cause 10
    step(1'b1, I_ADD, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_ADD, 1'b1, 1'b0, V_ID);
    step(1'b1, I_ADD, 1'b1, 1'b1, V_REX);
    step(1'b1, I_ADD, 1'b1, 1'b0, V_EXC_OVF);
    step(1'b1, I_ILL, 1'b0, 1'b0, V_IF0);  // cause cleared back in IF
    // illegal opcode 0x3F
    step(1'b1, I_ILL, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_ILL, 1'b1, 1'b0, V_ID);
    step(1'b1, I_ILL, 1'b1, 1'b0, V_EXC_ILL);
    // jalr
    step(1'b1, I_JALR, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_JALR, 1'b1, 1'b0, V_ID);
    step(1'b1, I_JALR, 1'b1, 1'b0, V_JALR);
    // add, no overflow -> writeback
    step(1'b1, I_ADD, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_ADD, 1'b1, 1'b0, V_ID);
    step(1'b1, I_ADD, 1'b1, 1'b0, V_REX);
    step(1'b1, I_ADD, 1'b1, 1'b0, V_RWB);
    // sw with one wait-state
    step(1'b1, I_SW, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_SW, 1'b1, 1'b0, V_ID);
    step(1'b1, I_SW, 1'b1, 1'b0, V_MEMEX);
    step(1'b1, I_SW, 1'b0, 1'b0, V_MEMW);
    step(1'b1, I_SW, 1'b1, 1'b0, V_MEMW);
    // beq / bne
    step(1'b1, I_BEQ, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_BEQ, 1'b1, 1'b0, V_ID);
    step(1'b1, I_BEQ, 1'b1, 1'b0, V_BEQ);
    step(1'b1, I_BNE, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_BNE, 1'b1, 1'b0, V_ID);
    step(1'b1, I_BNE, 1'b1, 1'b0, V_BNE);
    // andi (zero-extended imm) and lui
    step(1'b1, I_ANDI, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_ANDI, 1'b1, 1'b0, V_ID);
    step(1'b1, I_ANDI, 1'b1, 1'b0, V_IEX);
    step(1'b1, I_ANDI, 1'b1, 1'b0, V_IWB);
    step(1'b1, I_LUI, 1'b1, 1'b0, V_IF1);
    step(1'b1, I_LUI, 1'b1, 1'b0, V_ID);
    step(1'b1, I_LUI, 1'b1, 1'b0, V_LUI);
`ifdef MCTRL_TIMEOUT_EN
    // MIO_ready stuck low in IF: 15 wait cycles then EXC with cause 11
    for (int i = 0; i < 15; i++) step(1'b1, I_LW, 1'b0, 1'b0, V_IF0);
    step(1'b1, I_LW, 1'b0, 1'b0, V_EXC_TO);
    step(1'b1, I_LW, 1'b0, 1'b0, V_IF0);
`else
    // no timeout: IF waits indefinitely
    for (int i = 0; i < 20; i++) step(1'b1, I_LW, 1'b0, 1'b0, V_IF0);
`endif
    @(negedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
